rx_uart: RTL and testbench

RX_UART -- requirements
Module: rx_uart

---
 rtl/rx_uart.sv | 167 ++++++++++++++++
 tb/tb_rx_uart.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_uart.sv
// ---------------------------------------------------------------------------
// rx_uart -- 8N1 serial receiver with run-time selectable baud rate.
//
// Parameters:
//   CLK_FREQ  system clock frequency in Hz (bit divisor = CLK_FREQ / baud)
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   rst_n     asynchronous reset, active HIGH despite the name
//   rx        asynchronous serial input, idle high
//   baud_sel  0..7 -> 9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600
//   valid     one-cycle pulse when a byte with a good stop bit has arrived
//   data      last correctly received byte, held between pulses
// ---------------------------------------------------------------------------
module rx_uart #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic [2:0] baud_sel,
    output logic       valid,
    output logic [7:0] data
);

    // The slowest rate sets the counter width so a bit period never wraps.
    localparam int MAX_DIV = CLK_FREQ / 9600;
    localparam int CW      = $clog2(MAX_DIV + 1);

    function automatic int baud_rate(input int idx);
        case (idx)
            0:       baud_rate = 9600;
            1:       baud_rate = 19200;
            2:       baud_rate = 38400;
            3:       baud_rate = 57600;
            4:       baud_rate = 115200;
            5:       baud_rate = 230400;
            6:       baud_rate = 460800;
            default: baud_rate = 921600;
        endcase
    endfunction

    // Divisor lookup, all entries are elaboration-time constants.
    logic [CW-1:0] div_table [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_div
            localparam int DIV = CLK_FREQ / baud_rate(gi);
            assign div_table[gi] = CW'(DIV);
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state_reg;
    logic          rx_meta_reg;
    logic          rx_sync_reg;
    logic          rx_prev_reg;
    logic [2:0]    sel_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;
    logic          valid_reg;
    logic [7:0]    data_reg;

    // div_new uses the live select because it is latched in the same cycle
    // the start edge is seen; everything after that uses the latched copy.
    logic [CW-1:0] div_cur;
    logic [CW-1:0] div_new;

    assign div_cur = div_table[sel_reg];
    assign div_new = div_table[baud_sel];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_reg   <= IDLE;
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
            sel_reg     <= 3'd0;
            cnt_reg     <= '0;
            bit_cnt_reg <= 3'd0;
            shift_reg   <= 8'h00;
            valid_reg   <= 1'b0;
            data_reg    <= 8'h00;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
            valid_reg   <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (rx_prev_reg && !rx_sync_reg) begin
                        sel_reg     <= baud_sel;
                        bit_cnt_reg <= 3'd0;
                        // Count to the middle of the start bit.
                        cnt_reg     <= (div_new >> 1) - CW'(1);
                        state_reg   <= START;
                    end
                end

                START: begin
                    if (cnt_reg == '0) begin
                        if (!rx_sync_reg) begin
                            cnt_reg   <= div_cur - CW'(1);
                            state_reg <= DATA;
                        end else begin
                            // Line went back high: a glitch, not a start bit.
                            state_reg <= IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end

                DATA: begin
                    if (cnt_reg == '0) begin
                        // LSB arrives first, so shift in from the top.
                        shift_reg <= {rx_sync_reg, shift_reg[7:1]};
                        cnt_reg   <= div_cur - CW'(1);
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= STOP;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end

                STOP: begin
                    if (cnt_reg == '0) begin
                        if (rx_sync_reg) begin
                            data_reg  <= shift_reg;
                            valid_reg <= 1'b1;
                            state_reg <= IDLE;
                        end else begin
                            // Framing error: drop the byte, wait for idle line.
                            state_reg <= WAIT_IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end

                WAIT_IDLE: begin
                    if (rx_sync_reg) begin
                        state_reg <= IDLE;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;

endmodule

// File: tb/tb_rx_uart.sv
// ---------------------------------------------------------------------------
// tb_rx_uart -- self-checking bench for rx_uart.
// Runs the receiver at a 10 MHz system clock so the 9600 baud frame stays
// short in cycles. A serial-line driver produces 8N1 frames with bit periods
// taken from floor(CLK_FREQ / baud); the expected byte stream is the list of
// frames whose stop bit was high.
// ---------------------------------------------------------------------------
module tb_rx_uart;

    localparam int CLK_FREQ = 10_000_000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx = 1'b1;
    logic [2:0] baud_sel = 3'd4;
    logic       valid;
    logic [7:0] data;

    int checks = 0;
    int failures = 0;

    int         cyc = 0;
    int         start_cyc = 0;
    logic [7:0] got_q [$];
    int         got_cyc [$];
    int         wide_pulse = 0;
    int         data_glitch = 0;
    logic       valid_prev = 1'b0;
    logic [7:0] last_data = 8'h00;

    rx_uart #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .baud_sel (baud_sel),
        .valid    (valid),
        .data     (data)
    );

    always #50 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs mid-cycle: record every valid pulse, flag pulses wider
    // than one cycle and any data change that is not accompanied by valid.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            got_q.push_back(data);
            got_cyc.push_back(cyc);
            if (valid_prev === 1'b1) wide_pulse <= wide_pulse + 1;
        end
        if (!rst_n && valid !== 1'b1 && data !== last_data) data_glitch <= data_glitch + 1;
        valid_prev <= valid;
        last_data  <= data;
    end

    function automatic int bit_cycles(input int sel);
        int rates [8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};
        return CLK_FREQ / rates[sel];
    endfunction

    task automatic send_bit(input logic v, input int d);
        rx = v;
        repeat (d) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int d, input logic stop_bit);
        start_cyc = cyc;
        send_bit(1'b0, d);
        for (int i = 0; i < 8; i++) send_bit(b[i], d);
        send_bit(stop_bit, d);
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid: got %b expected 0", valid);
        end
        checks++;
        if (data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: got %h expected 00", data);
        end
        rst_n = 1'b0;
        got_q.delete();
        repeat (300) @(negedge clk);
        checks++;
        if (got_q.size() != 0) begin
            failures++;
            $display("FAIL idle_no_valid: got %0d pulses expected 0", got_q.size());
        end
        $display("test_reset: pulses=%0d data=%h", got_q.size(), data);
    endtask

    task automatic test_basic;
        int d = bit_cycles(4);
        int lat;
        baud_sel = 3'd4;
        got_q.delete();
        got_cyc.delete();
        send_frame(8'hAA, d, 1'b1);
        checks++;
        if (got_q.size() != 1) begin
            failures++;
            $display("FAIL aa_count: got %0d pulses expected 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 8'hAA) begin
                failures++;
                $display("FAIL aa_value: got %h expected aa", got_q[0]);
            end
            lat = got_cyc[0] - start_cyc;
            checks++;
            if (2 * lat > 19 * d + 8) begin
                failures++;
                $display("FAIL aa_latency: got %0d cycles limit %0d", lat, (19 * d + 8) / 2);
            end
        end
        $display("test_basic: frame aa pulses=%0d data=%h", got_q.size(), data);
        got_q.delete();
        // Next frame starts the instant the stop bit ends; 0xAA must hold.
        send_bit(1'b0, d);
        for (int i = 0; i < 4; i++) send_bit(((8'h55 >> i) & 8'h01) != 0, d);
        checks++;
        if (data !== 8'hAA) begin
            failures++;
            $display("FAIL aa_hold: got %h expected aa", data);
        end
        for (int i = 4; i < 8; i++) send_bit(((8'h55 >> i) & 8'h01) != 0, d);
        send_bit(1'b1, d);
        checks++;
        if (got_q.size() != 1 || data !== 8'h55) begin
            failures++;
            $display("FAIL b2b_55: got %0d pulses data %h expected 1 pulse data 55", got_q.size(), data);
        end
        $display("test_basic: frame 55 pulses=%0d data=%h", got_q.size(), data);
    endtask

    task automatic test_multi_baud;
        baud_sel = 3'd0;
        got_q.delete();
        send_frame(8'hFF, bit_cycles(0), 1'b1);
        checks++;
        if (got_q.size() != 1 || data !== 8'hFF) begin
            failures++;
            $display("FAIL baud9600_ff: got %0d pulses data %h expected 1 pulse data ff", got_q.size(), data);
        end
        $display("test_multi_baud: 9600 pulses=%0d data=%h", got_q.size(), data);
        repeat (20) @(negedge clk);
        baud_sel = 3'd2;
        got_q.delete();
        send_frame(8'hF0, bit_cycles(2), 1'b1);
        checks++;
        if (got_q.size() != 1 || data !== 8'hF0) begin
            failures++;
            $display("FAIL baud38400_f0: got %0d pulses data %h expected 1 pulse data f0", got_q.size(), data);
        end
        $display("test_multi_baud: 38400 pulses=%0d data=%h", got_q.size(), data);
    endtask

    task automatic test_glitch;
        int d = bit_cycles(4);
        baud_sel = 3'd4;
        got_q.delete();
        send_bit(1'b0, d / 4);
        send_bit(1'b1, 2 * d);
        checks++;
        if (got_q.size() != 0 || data !== 8'hF0) begin
            failures++;
            $display("FAIL glitch_reject: got %0d pulses data %h expected 0 pulses data f0", got_q.size(), data);
        end
        send_frame(8'h3C, d, 1'b1);
        checks++;
        if (got_q.size() != 1 || data !== 8'h3C) begin
            failures++;
            $display("FAIL glitch_then_3c: got %0d pulses data %h expected 1 pulse data 3c", got_q.size(), data);
        end
        $display("test_glitch: pulses=%0d data=%h", got_q.size(), data);
    endtask

    task automatic test_framing;
        int d = bit_cycles(4);
        got_q.delete();
        send_frame(8'h12, d, 1'b0);
        send_bit(1'b1, 2 * d);
        checks++;
        if (got_q.size() != 0 || data !== 8'h3C) begin
            failures++;
            $display("FAIL framing_drop: got %0d pulses data %h expected 0 pulses data 3c", got_q.size(), data);
        end
        send_frame(8'h34, d, 1'b1);
        checks++;
        if (got_q.size() != 1 || data !== 8'h34) begin
            failures++;
            $display("FAIL framing_recover: got %0d pulses data %h expected 1 pulse data 34", got_q.size(), data);
        end
        $display("test_framing: pulses=%0d data=%h", got_q.size(), data);
    endtask

    task automatic test_reset_mid_frame;
        int d = bit_cycles(4);
        logic [7:0] b = 8'hA5;
        got_q.delete();
        send_bit(1'b0, d);
        for (int i = 0; i < 4; i++) send_bit(b[i], d);
        send_bit(b[4], d / 2);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        rst_n = 1'b0;
        repeat (12 * d) @(negedge clk);
        checks++;
        if (got_q.size() != 0 || data !== 8'h00) begin
            failures++;
            $display("FAIL reset_abort: got %0d pulses data %h expected 0 pulses data 00", got_q.size(), data);
        end
        send_frame(8'hA5, d, 1'b1);
        checks++;
        if (got_q.size() != 1 || data !== 8'hA5) begin
            failures++;
            $display("FAIL reset_recover_a5: got %0d pulses data %h expected 1 pulse data a5", got_q.size(), data);
        end
        $display("test_reset_mid_frame: pulses=%0d data=%h", got_q.size(), data);
    endtask

    task automatic test_baud_latch;
        int d = bit_cycles(7);
        logic [7:0] b = 8'($urandom_range(0, 255));
        baud_sel = 3'd7;
        got_q.delete();
        send_bit(1'b0, d);
        // Changing the select mid-frame must not disturb the current frame.
        baud_sel = 3'd0;
        for (int i = 0; i < 8; i++) send_bit(b[i], d);
        send_bit(1'b1, d);
        checks++;
        if (got_q.size() != 1 || data !== b) begin
            failures++;
            $display("FAIL baud_latch: got %0d pulses data %h expected 1 pulse data %h", got_q.size(), data, b);
        end
        $display("test_baud_latch: sent=%h pulses=%0d data=%h", b, got_q.size(), data);
    endtask

    task automatic test_back_to_back;
        int sel = $urandom_range(5, 7);
        int d = bit_cycles(sel);
        logic [7:0] exp_q [$];
        logic [7:0] b;
        logic ok;
        baud_sel = 3'(sel);
        got_q.delete();
        for (int n = 0; n < 12; n++) begin
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 4) != 0);
            send_frame(b, d, ok);
            if (ok) exp_q.push_back(b);
            else send_bit(1'b1, d);
            $display("test_back_to_back: sel=%0d byte=%h stop=%b", sel, b, ok);
        end
        repeat (2 * d) @(negedge clk);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL b2b_count: got %0d pulses expected %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL b2b_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_integrity;
        checks++;
        if (wide_pulse != 0) begin
            failures++;
            $display("FAIL valid_width: got %0d wide pulses expected 0", wide_pulse);
        end
        checks++;
        if (data_glitch != 0) begin
            failures++;
            $display("FAIL data_stable: got %0d unannounced data changes expected 0", data_glitch);
        end
        $display("test_integrity: wide=%0d glitches=%0d", wide_pulse, data_glitch);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_baud();
        test_glitch();
        test_framing();
        test_reset_mid_frame();
        test_baud_latch();
        test_back_to_back();
        test_integrity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
